// File: rtl/spi_text_writer.sv
// SPI (mode 0, MSB first) byte receiver feeding a cursor-addressed text RAM write stream,
// with control-code decoding and a hardware clear-screen sequencer.
module spi_text_writer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        busy,
  output logic        frame_err,
  output logic        rx_overrun
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_ONE = CW'(1);
  localparam logic [RW-1:0] ROW_ONE = RW'(1);
  localparam logic [11:0]   COLS_A  = 12'(COLS);
  localparam logic [11:0]   CELLS_A = 12'(COLS * ROWS);
  localparam logic [AW:0]   DEPTH_A = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  // synchronisers; third stage on sck/cs_n gives edge detection
  logic [2:0] sck_s, cs_s;
  logic [1:0] mosi_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s  <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sck_s  <= {sck_s[1:0], spi_sck};
      cs_s   <= {cs_s[1:0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  end

  logic sck_rise, cs_fall, cs_rise;
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign cs_fall  = ~cs_s[1] & cs_s[2];
  assign cs_rise  = cs_s[1] & ~cs_s[2];

  logic [2:0] bit_cnt;
  logic [6:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (cs_fall) begin
        bit_cnt <= 3'd0;
        shreg   <= 7'd0;
      end else if (cs_rise) begin
        frame_err <= (bit_cnt != 3'd0);
        bit_cnt   <= 3'd0;
        shreg     <= 7'd0;
      end else if (sck_rise && !cs_s[1]) begin
        shreg   <= {shreg[5:0], mosi_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte  <= {shreg, mosi_s[1]};
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // receive FIFO: rx_valid/rx_byte act directly as the push port
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        empty, full, pop, push_ok;
  logic [7:0]  head;
  state_t      state;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == DEPTH_A);
  assign pop     = (state == IDLE) && !empty;
  assign push_ok = rx_valid && (!full || pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (rx_valid && !push_ok) rx_overrun <= 1'b1;
    end
  end

  // cursor is tracked as (col,row) with a running row base, so address = row_base + col
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [11:0]   row_base;
  logic [11:0]   clr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      row_base <= 12'd0;
      clr_cnt  <= 12'd0;
      wr_en    <= 1'b0;
      wr_addr  <= 12'd0;
      wr_data  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            case (head)
              8'h0D: col <= '0;
              8'h0A: begin
                col <= '0;
                if (row == ROW_MAX) begin
                  row      <= '0;
                  row_base <= 12'd0;
                end else begin
                  row      <= row + ROW_ONE;
                  row_base <= row_base + COLS_A;
                end
              end
              8'h08: begin
                if (col != '0) begin
                  col <= col - COL_ONE;
                end else if (row != '0) begin
                  col      <= COL_MAX;
                  row      <= row - ROW_ONE;
                  row_base <= row_base - COLS_A;
                end
              end
              8'h0C: begin
                state   <= CLEAR;
                busy    <= 1'b1;
                wr_en   <= 1'b1;
                wr_addr <= 12'd0;
                wr_data <= 8'h20;
                clr_cnt <= 12'd1;
              end
              default: begin
                wr_en   <= 1'b1;
                wr_addr <= row_base + {{(12-CW){1'b0}}, col};
                wr_data <= head;
                if (col == COL_MAX) begin
                  col <= '0;
                  if (row == ROW_MAX) begin
                    row      <= '0;
                    row_base <= 12'd0;
                  end else begin
                    row      <= row + ROW_ONE;
                    row_base <= row_base + COLS_A;
                  end
                end else begin
                  col <= col + COL_ONE;
                end
              end
            endcase
          end
        end
        CLEAR: begin
          if (clr_cnt == CELLS_A) begin
            state    <= IDLE;
            busy     <= 1'b0;
            col      <= '0;
            row      <= '0;
            row_base <= 12'd0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= clr_cnt;
            wr_data <= 8'h20;
            clr_cnt <= clr_cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_text_writer.sv
// Directed bench for spi_text_writer: bit-banged SPI host plus a write/strobe monitor.
module tb_spi_text_writer;
  localparam time HALF = 40ns;

  logic        clk = 1'b0, rst = 1'b1;
  logic        spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic        wr_en, rx_valid, busy, frame_err, rx_overrun;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data, rx_byte;

  spi_text_writer dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .busy(busy), .frame_err(frame_err), .rx_overrun(rx_overrun)
  );

  always #10ns clk = ~clk;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { logic [7:0] b; bit wr; int addr; } vec_t;

  int  cyc = 0;
  wr_t wq[$];
  int  rx_cnt = 0, rx_cyc = 0, fe_cnt = 0, busy_cnt = 0;
  int  pass = 0, total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) wq.push_back('{int'(wr_addr), int'(wr_data), cyc});
      if (rx_valid) begin rx_cnt++; rx_cyc = cyc; end
      if (frame_err) fe_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      #HALF spi_sck = 1'b1;
      #HALF spi_sck = 1'b0;
    end
    #HALF spi_cs_n = 1'b1;
    #HALF;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  // wait for a complete clear sequence (busy seen, then low); returns 1 on timeout
  task automatic wait_clear_done(input int b0, output bit to);
    int t = 0;
    while (!(busy_cnt > b0 && !busy) && t < 6000) begin
      @(posedge clk);
      t++;
    end
    to = (t >= 6000);
  endtask

  vec_t vecs[14];

  initial begin
    int wb, rb, fb, bb, bad, n;
    bit to;

    vecs[0]  = '{8'h41, 1'b1, 0};
    vecs[1]  = '{8'h42, 1'b1, 1};
    vecs[2]  = '{8'h0D, 1'b0, 0};
    vecs[3]  = '{8'h58, 1'b1, 0};
    vecs[4]  = '{8'h0A, 1'b0, 0};
    vecs[5]  = '{8'h59, 1'b1, 80};
    vecs[6]  = '{8'h0D, 1'b0, 0};
    vecs[7]  = '{8'h5A, 1'b1, 80};
    vecs[8]  = '{8'h08, 1'b0, 0};
    vecs[9]  = '{8'h08, 1'b0, 0};
    vecs[10] = '{8'h00, 1'b1, 79};
    vecs[11] = '{8'h08, 1'b0, 0};
    vecs[12] = '{8'hFF, 1'b1, 79};
    vecs[13] = '{8'h80, 1'b1, 80};

    #5;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    do_reset();
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_rx_byte", int'(rx_byte), 0);
    chk("rst_overrun", int'(rx_overrun), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);

    // table: one byte per entry, check strobe, held rx_byte, write and latency
    foreach (vecs[k]) begin
      wb = wq.size(); rb = rx_cnt;
      send_byte(vecs[k].b);
      repeat (6) @(posedge clk);
      chk($sformatf("v%0d_rx_cnt", k), rx_cnt - rb, 1);
      chk($sformatf("v%0d_rx_byte", k), int'(rx_byte), int'(vecs[k].b));
      chk($sformatf("v%0d_nwr", k), wq.size() - wb, int'(vecs[k].wr));
      if (vecs[k].wr && wq.size() > wb) begin
        chk($sformatf("v%0d_addr", k), wq[wb].addr, vecs[k].addr);
        chk($sformatf("v%0d_data", k), wq[wb].data, int'(vecs[k].b));
        chk($sformatf("v%0d_lat", k), wq[wb].cyc - rx_cyc, 2);
      end
    end

    // bottom row fill and wrap of the last cell back to 0
    do_reset();
    wb = wq.size();
    repeat (29) send_byte(8'h0A);
    repeat (80) send_byte(8'h2E);
    send_byte(8'h21);
    repeat (6) @(posedge clk);
    chk("row29_nwr", wq.size() - wb, 81);
    if (wq.size() - wb == 81) begin
      bad = 0;
      for (int i = 0; i < 80; i++)
        if (wq[wb+i].addr != 2320 + i || wq[wb+i].data != 8'h2E) bad++;
      chk("row29_dots_bad", bad, 0);
      chk("row29_last_dot", wq[wb+79].addr, 2399);
      chk("wrap_addr", wq[wb+80].addr, 0);
      chk("wrap_data", wq[wb+80].data, 8'h21);
    end
    wb = wq.size();
    send_byte(8'h08);
    send_byte(8'h08);
    send_byte(8'h41);
    repeat (6) @(posedge clk);
    chk("bs0_nwr", wq.size() - wb, 1);
    if (wq.size() > wb) chk("bs0_addr", wq[wb].addr, 0);

    // clear screen with a byte queued behind it
    do_reset();
    wb = wq.size(); bb = busy_cnt;
    send_byte(8'h0C);
    send_byte(8'h41);
    wait_clear_done(bb, to);
    chk("clr_timeout", int'(to), 0);
    repeat (10) @(posedge clk);
    chk("clr_busy_cycles", busy_cnt - bb, 2400);
    chk("clr_nwr", wq.size() - wb, 2401);
    if (wq.size() - wb == 2401) begin
      bad = 0;
      for (int i = 0; i < 2400; i++)
        if (wq[wb+i].addr != i || wq[wb+i].data != 8'h20) bad++;
      chk("clr_cells_bad", bad, 0);
      chk("clr_contig", wq[wb+2399].cyc - wq[wb].cyc, 2399);
      chk("clr_next_addr", wq[wb+2400].addr, 0);
      chk("clr_next_data", wq[wb+2400].data, 8'h41);
      chk("clr_next_gap", int'(wq[wb+2400].cyc - wq[wb+2399].cyc >= 2), 1);
    end

    // overrun: 17 bytes during a clear, only 16 fit
    do_reset();
    wb = wq.size(); bb = busy_cnt; rb = rx_cnt;
    send_byte(8'h0C);
    for (int i = 0; i < 17; i++) send_byte(8'(8'h61 + i));
    chk("ovr_during_clear", int'(busy), 1);
    wait_clear_done(bb, to);
    chk("ovr_timeout", int'(to), 0);
    repeat (30) @(posedge clk);
    chk("ovr_rx_cnt", rx_cnt - rb, 18);
    chk("ovr_nwr", wq.size() - wb, 2416);
    if (wq.size() - wb == 2416) begin
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (wq[wb+2400+i].addr != i || wq[wb+2400+i].data != 8'h61 + i) bad++;
      chk("ovr_queued_bad", bad, 0);
    end
    chk("ovr_flag", int'(rx_overrun), 1);
    send_byte(8'h30);
    repeat (6) @(posedge clk);
    chk("ovr_sticky", int'(rx_overrun), 1);

    // partial byte aborted by cs_n, then a full byte
    do_reset();
    chk("ovr_cleared", int'(rx_overrun), 0);
    wb = wq.size(); fb = fe_cnt; rb = rx_cnt;
    send_bits(8'hA5, 5);
    repeat (4) @(posedge clk);
    chk("fe_cnt", fe_cnt - fb, 1);
    chk("fe_no_rx", rx_cnt - rb, 0);
    send_byte(8'h43);
    repeat (6) @(posedge clk);
    chk("fe_once", fe_cnt - fb, 1);
    chk("fe_nwr", wq.size() - wb, 1);
    if (wq.size() > wb) begin
      chk("fe_addr", wq[wb].addr, 0);
      chk("fe_data", wq[wb].data, 8'h43);
    end

    // reset asserted in the middle of a clear
    do_reset();
    bb = busy_cnt;
    send_byte(8'h0C);
    n = 0;
    while (!busy && n < 200) begin @(posedge clk); n++; end
    chk("rclr_busy_seen", int'(busy), 1);
    repeat (100) @(posedge clk);
    #2 rst = 1'b1;
    n = wq.size();
    @(negedge clk);
    chk("rclr_wr_en", int'(wr_en), 0);
    chk("rclr_busy", int'(busy), 0);
    chk("rclr_wr_addr", int'(wr_addr), 0);
    chk("rclr_wr_data", int'(wr_data), 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("rclr_no_writes", wq.size() - n, 0);
    chk("rclr_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/spi_text_writer.md
# spi_text_writer

Upstream feeder for the text-mode framebuffer: receives ASCII bytes from an external host over SPI (mode 0, MSB first), decodes a small set of control codes, tracks a text cursor, and issues single-cycle writes into the framebuffer's text RAM write port. It replaces the raw shift-register/done-strobe hand-off with a synchronised, buffered, cursor-addressed write stream. A hardware clear-screen sequencer is also included.

## Interface
- COLS, 80, characters per row
- ROWS, 30, rows per screen (COLS*ROWS = 2400 cells)
- FIFO_DEPTH, 16, receive byte FIFO depth (power of 2)
- clk  in  1  core clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- spi_sck  in  1  SPI clock from host, asynchronous; must be ≤ clk/4
- spi_mosi  in  1  SPI data from host, asynchronous
- spi_cs_n  in  1  SPI chip select, active low, asynchronous
- wr_en  out  1  text RAM write enable, one-cycle pulses
- wr_addr  out  12  text RAM write address, 0..2399
- wr_data  out  8  text RAM write data (glyph code)
- rx_valid  out  1  one-cycle strobe: a complete byte was received
- rx_byte  out  8  last received byte, valid while rx_valid is high and held afterwards
- busy  out  1  clear sequence in progress
- frame_err  out  1  one-cycle strobe: cs_n deasserted mid-byte
- rx_overrun  out  1  sticky: byte dropped because the FIFO was full; cleared only by rst

## Operation
- Sync: spi_sck, spi_mosi, spi_cs_n each pass through 2 flops, plus a third flop on sck and cs_n for edge detection. Reset values: sck=0, mosi=0, cs_n=1.
- Receiver:
  - Synced cs_n falling edge clears bit_cnt (3 b) and the shift register.
  - Each synced sck rising edge with cs_n low shifts synced mosi in at the LSB.
  - On the 8th bit: rx_byte takes the full byte, rx_valid pulses, the byte is pushed to the FIFO, and bit_cnt wraps to 0.
  - cs_n rising with bit_cnt≠0: the partial byte is discarded and frame_err pulses. With bit_cnt=0: no error.
- FIFO:
  - Push when full: the byte is dropped and rx_overrun is set. The byte still appears on rx_byte/rx_valid.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- Cursor: col 0..COLS-1, row 0..ROWS-1; linear address = row*COLS+col. No multiplier in the write path; keep a registered row base.
- FSM states IDLE and CLEAR.
  - IDLE, FIFO non-empty: pop one byte per cycle and act on it:
    - 0x0D (CR): col←0. No write.
    - 0x0A (LF): col←0, row←row+1; row ROWS-1 wraps to 0 (no scrolling). No write.
    - 0x08 (BS): if linear address >0, step back one cell (col 0 goes to COLS-1 of the previous row). No write.
    - 0x0C (FF): go to CLEAR. No write.
    - Any other byte (including 0x00 and 0x80–0xFF): write to the current cell, then advance the cursor. Col wraps to 0 and row increments; cell 2399 wraps to 0.
  - CLEAR: busy=1; writes 0x20 to addresses 0,1,…,2399 on consecutive cycles (wr_en high 2400 cycles). After address 2399: cursor←0, return to IDLE. The FIFO is not popped during CLEAR; received bytes keep queuing.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, rx_valid=0, rx_byte=0, busy=0, frame_err=0, rx_overrun=0. FIFO empty, cursor 0, state IDLE.
- Reset mid-CLEAR or mid-byte aborts immediately. Screen contents are left as-is and no further writes occur.

## Timing
- Pin sck edge to synced edge detect: 2–3 clk. rx_valid is high in cycle t, where t ≤ 3 clk after the 8th sck rising edge at the pin.
- FIFO push at the end of cycle t; pop decision in t+1; wr_en/wr_addr/wr_data registered and high in cycle t+2. The write-path latency is 2 clk.
- Sustained throughput is 1 byte/clk from the FIFO. Each SPI byte takes ≥32 clk, so the FIFO never fills in IDLE.
- FF popped in cycle p: busy and the first clear write (addr 0) occur in p+1; the last write (addr 2399) occurs in p+2400. busy falls in p+2401. The next queued byte is written no earlier than p+2402.
- Host constraint: ≤FIFO_DEPTH bytes may be sent during a clear; excess bytes are dropped and set rx_overrun.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then send 0x41 0x42: wr_en pulses with (addr 0, data 0x41) and (addr 1, data 0x42); each write occurs 2 clk after its rx_valid.
- Send 0x58, 0x0A, 0x59: writes (0,0x58) then (80,0x59). Send 0x0D 0x5A: write (80,0x5A).
- Set cursor to row 29 via 29 LFs, send 80 × 0x2E then 0x21: last dot at addr 2399, 0x21 written to addr 0. Send 0x08 at addr 0: no write, cursor stays 0.
- Send 0x0C then 0x41 immediately: busy high 2400 clk, 2400 writes of 0x20 to addresses 0..2399, then (0,0x41).
- Send 0x0C followed by 17 bytes back-to-back at max sck: first 16 written after clear; 17th dropped; rx_overrun=1 until rst.
- Raise cs_n after 5 bits, then send 0x43: frame_err pulses once, no write for the partial byte; 0x43 written at the correct cursor. Assert rst during CLEAR: writes stop within 1 clk, all outputs return to reset values.
